adc_samp_sched: RTL and testbench

- Parametrised, multi-channel successor to the single-channel ADC sample-rate trigger.
- Generates single-cycle sample triggers at a programmable period and tags each trigger with a round-robin channel index over an enable mask.
- Supports continuous mode and counted burst mode.
- Sits between the control register block and the ADC interface FSM; the ADC interface consumes samp_trig_out and ch_sel_out.

---
 rtl/adc_samp_sched.sv | 200 ++++++++++++++++++++
 tb/tb_adc_samp_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_samp_sched.sv
// adc_samp_sched
//   Multi-channel ADC sample scheduler. Emits one-cycle sample triggers every
//   period_in+1 clocks and tags each with a round-robin channel index taken
//   from the enable mask. Runs continuously (mode_in=0) or for a counted
//   burst of burst_len_in triggers (mode_in=1).
//
// Optional feature macro: ADC_SAMP_SCHED_CNT_EN
//   When defined, adds trig_cnt_out[15:0], a saturating count of emitted
//   triggers that clears on reset and on every IDLE->RUN transition.
//
// Ports:
//   clk_in        - system clock, rising edge
//   rst_in        - synchronous active-low reset
//   en_in         - block enable; low forces IDLE on the next edge
//   mode_in       - 0 = continuous, 1 = burst (latched on entry to RUN)
//   start_in      - burst start pulse, sampled in IDLE only
//   period_in     - trigger period minus one
//   burst_len_in  - triggers per burst
//   ch_mask_in    - channel enable mask
//   samp_trig_out - one-cycle sample trigger (gated by en_in)
//   ch_sel_out    - channel index, valid with samp_trig_out
//   busy_out      - high while in RUN
//   done_out      - one-cycle pulse after the last burst trigger
//   trig_cnt_out  - (optional) saturating trigger count
module adc_samp_sched #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned NCH     = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned BURST_W = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               en_in,
  input  logic               mode_in,
  input  logic               start_in,
  input  logic [CNT_W-1:0]   period_in,
  input  logic [BURST_W-1:0] burst_len_in,
  input  logic [NCH-1:0]     ch_mask_in,
  output logic               samp_trig_out,
  output logic [CH_W-1:0]    ch_sel_out,
  output logic               busy_out,
  output logic               done_out
`ifdef ADC_SAMP_SCHED_CNT_EN
  ,
  output logic [15:0]        trig_cnt_out
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam int unsigned MASK_EXT_W = 1 << CH_W;

  state_t              state;
  logic [CNT_W-1:0]    per_cnt;
  logic [BURST_W-1:0]  burst_cnt;
  logic [CH_W-1:0]     ch_ptr;
  logic                burst_mode;
  logic                trig_q;
  logic [CH_W-1:0]     ch_q;
  logic                busy_q;
  logic                done_q;

  logic [MASK_EXT_W-1:0] mask_ext;
  logic                  mask_any;
  logic                  ptr_hit;
  logic [CH_W-1:0]       first_ptr;
  logic [CH_W-1:0]       next_ptr;

  // Lowest set bit of the mask; 0 when the mask is empty.
  function automatic logic [CH_W-1:0] first_ch(input logic [NCH-1:0] m);
    logic [CH_W-1:0] r;
    logic            found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && m[i]) begin
        r     = CH_W'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Next set bit strictly above cur, wrapping to the lowest set bit.
  function automatic logic [CH_W-1:0] next_ch(input logic [NCH-1:0] m,
                                              input logic [CH_W-1:0] cur);
    logic [CH_W-1:0] r;
    logic            found;
    r     = first_ch(m);
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && m[i] && (i > 32'(cur))) begin
        r     = CH_W'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Widen the mask to the full index range so ch_ptr can index it directly.
  assign mask_ext  = MASK_EXT_W'(ch_mask_in);
  assign mask_any  = |ch_mask_in;
  assign ptr_hit   = mask_ext[ch_ptr];
  assign first_ptr = first_ch(ch_mask_in);
  assign next_ptr  = next_ch(ch_mask_in, ch_ptr);

`ifdef ADC_SAMP_SCHED_CNT_EN
  logic [15:0] trig_cnt;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state      <= ST_IDLE;
      per_cnt    <= '0;
      burst_cnt  <= '0;
      ch_ptr     <= '0;
      burst_mode <= 1'b0;
      trig_q     <= 1'b0;
      ch_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ADC_SAMP_SCHED_CNT_EN
      trig_cnt   <= '0;
`endif
    end else begin
      trig_q <= 1'b0;
      done_q <= 1'b0;
      if (!en_in) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!mode_in || start_in) begin
              state      <= ST_RUN;
              busy_q     <= 1'b1;
              burst_mode <= mode_in;
              per_cnt    <= period_in;
              burst_cnt  <= burst_len_in;
              ch_ptr     <= first_ptr;
`ifdef ADC_SAMP_SCHED_CNT_EN
              trig_cnt   <= '0;
`endif
            end
          end
          ST_RUN: begin
            if (burst_mode && (burst_cnt == '0)) begin
              // Exhausted (or zero-length) burst: finish without a trigger.
              state  <= ST_DONE;
              busy_q <= 1'b0;
            end else if (per_cnt == '0) begin
              per_cnt <= period_in;
              // Empty mask: period keeps running, pointer and burst hold.
              if (mask_any) begin
                ch_ptr <= next_ptr;
              end
              // A cleared current-pointer bit suppresses this trigger.
              if (ptr_hit) begin
                trig_q <= 1'b1;
                ch_q   <= ch_ptr;
`ifdef ADC_SAMP_SCHED_CNT_EN
                if (trig_cnt != 16'hFFFF) begin
                  trig_cnt <= trig_cnt + 16'd1;
                end
`endif
                if (burst_mode) begin
                  burst_cnt <= burst_cnt - BURST_W'(1);
                  if (burst_cnt == BURST_W'(1)) begin
                    state  <= ST_DONE;
                    busy_q <= 1'b0;
                  end
                end
              end
            end else begin
              per_cnt <= per_cnt - CNT_W'(1);
            end
          end
          ST_DONE: begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Trigger drops in the same cycle en_in falls.
  assign samp_trig_out = trig_q & en_in;
  assign ch_sel_out    = ch_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
`ifdef ADC_SAMP_SCHED_CNT_EN
  assign trig_cnt_out  = trig_cnt;
`endif

endmodule

// File: tb/tb_adc_samp_sched.sv
// Bench for adc_samp_sched: a clocks-until-trigger model is compared to the
// DUT every cycle, and directed scenarios pin sequences with literal values.
module tb_adc_samp_sched;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned NCH     = 4;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned BURST_W = 8;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               en_in;
  logic               mode_in;
  logic               start_in;
  logic [CNT_W-1:0]   period_in;
  logic [BURST_W-1:0] burst_len_in;
  logic [NCH-1:0]     ch_mask_in;
  logic               samp_trig_out;
  logic [CH_W-1:0]    ch_sel_out;
  logic               busy_out;
  logic               done_out;
`ifdef ADC_SAMP_SCHED_CNT_EN
  logic [15:0]        trig_cnt_out;
`endif

  adc_samp_sched #(
    .CNT_W(CNT_W), .NCH(NCH), .CH_W(CH_W), .BURST_W(BURST_W)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .mode_in(mode_in),
    .start_in(start_in), .period_in(period_in), .burst_len_in(burst_len_in),
    .ch_mask_in(ch_mask_in), .samp_trig_out(samp_trig_out),
    .ch_sel_out(ch_sel_out), .busy_out(busy_out), .done_out(done_out)
`ifdef ADC_SAMP_SCHED_CNT_EN
    , .trig_cnt_out(trig_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_st = 0;        // 0 idle, 1 run, 2 done
  int m_mode = 0;
  int m_till = 0;      // clocks left until the next trigger boundary
  int m_bleft = 0;
  int m_ptr = 0;
  int m_trig = 0;
  int m_ch = 0;
  int m_done = 0;
  int m_cnt = 0;
  bit mdl_valid = 0;

  function automatic int lowest(input logic [NCH-1:0] m);
    for (int k = 0; k < NCH; k++) if (m[k]) return k;
    return 0;
  endfunction

  function automatic int nxt(input logic [NCH-1:0] m, input int p);
    for (int k = 1; k <= NCH; k++) if (m[(p + k) % NCH]) return (p + k) % NCH;
    return p;
  endfunction

  always @(posedge clk_in) begin
    if (!rst_in) begin
      m_st = 0; m_trig = 0; m_done = 0; m_ch = 0; m_ptr = 0;
      m_till = 0; m_bleft = 0; m_cnt = 0; mdl_valid = 1;
    end else begin
      m_trig = 0;
      m_done = 0;
      if (!en_in) begin
        m_st = 0;
      end else if (m_st == 0) begin
        if (!mode_in || start_in) begin
          m_st = 1; m_mode = int'(mode_in);
          m_till = int'(period_in) + 1;
          m_bleft = int'(burst_len_in);
          m_ptr = lowest(ch_mask_in);
          m_cnt = 0;
        end
      end else if (m_st == 1) begin
        if (m_mode == 1 && m_bleft == 0) begin
          m_st = 2;
        end else begin
          m_till--;
          if (m_till == 0) begin
            m_till = int'(period_in) + 1;
            if (ch_mask_in != 0) begin
              if (ch_mask_in[m_ptr]) begin
                m_trig = 1; m_ch = m_ptr;
                if (m_cnt < 65535) m_cnt++;
                if (m_mode == 1) begin
                  m_bleft--;
                  if (m_bleft == 0) m_st = 2;
                end
              end
              m_ptr = nxt(ch_mask_in, m_ptr);
            end
          end
        end
      end else begin
        m_done = 1;
        m_st = 0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk_in) begin
    #1;
    if (mdl_valid) begin
      chk("trig", int'(samp_trig_out), m_trig & int'(en_in));
      if (m_trig == 1 && en_in) chk("ch_sel", int'(ch_sel_out), m_ch);
      chk("busy", int'(busy_out), int'(m_st == 1));
      chk("done", int'(done_out), m_done);
`ifdef ADC_SAMP_SCHED_CNT_EN
      chk("trig_cnt", int'(trig_cnt_out), m_cnt);
`endif
    end
  end

  // ---------------- event monitor ----------------
  int cyc = 0;
  int tq[$];
  int cq[$];
  int n_done = 0;
  int done_cyc = 0;
  int rise_cyc = 0;
  logic busy_prev = 1'b0;

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    #1;
    if (samp_trig_out === 1'b1) begin
      tq.push_back(cyc);
      cq.push_back(int'(ch_sel_out));
    end
    if (done_out === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy_out === 1'b1 && busy_prev !== 1'b1) rise_cyc = cyc;
    busy_prev = busy_out;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic clear_mon();
    tq.delete();
    cq.delete();
    n_done = 0;
  endtask

  task automatic start_pulse();
    start_in = 1'b1;
    clear_mon();
    tick(1);
    start_in = 1'b0;
  endtask

  int exp1[6] = '{0, 1, 3, 0, 1, 3};
  int exp5[6] = '{1, 2, 1, 2, 1, 2};
  int mset;

  initial begin
    rst_in = 1'b0; en_in = 1'b1; mode_in = 1'b0; start_in = 1'b0;
    period_in = 16'd3; burst_len_in = 8'd0; ch_mask_in = 4'b1011;
    tick(3);

    // Continuous, period 3, mask 1011
    rst_in = 1'b1;
    clear_mon();
    tick(27);
    chk("t1_ntrig_ge6", int'(tq.size() >= 6), 1);
    if (tq.size() >= 6) begin
      chk("t1_first_offset", tq[0] - rise_cyc, 4);
      for (int i = 0; i < 6; i++) chk("t1_ch_seq", cq[i], exp1[i]);
      for (int i = 1; i < 6; i++) chk("t1_interval", tq[i] - tq[i-1], 4);
    end
`ifdef ADC_SAMP_SCHED_CNT_EN
    chk("t1_trig_cnt", int'(trig_cnt_out), 6);
`endif

    // Burst of 5, period 0, mask 0100
    en_in = 1'b0; mode_in = 1'b1; period_in = 16'd0; burst_len_in = 8'd5;
    ch_mask_in = 4'b0100;
    tick(1);
    en_in = 1'b1;
    start_pulse();
    tick(10);
    chk("t2_ntrig", tq.size(), 5);
    if (tq.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("t2_ch", cq[i], 2);
      chk("t2_consecutive", tq[4] - tq[0], 4);
      chk("t2_first_offset", tq[0] - rise_cyc, 1);
      chk("t2_done_after_last", done_cyc - tq[4], 1);
    end
    chk("t2_ndone", n_done, 1);
    chk("t2_busy_end", int'(busy_out), 0);

    // Zero-length burst
    burst_len_in = 8'd0;
    start_pulse();
    tick(6);
    chk("t3_ntrig", tq.size(), 0);
    chk("t3_ndone", n_done, 1);
    chk("t3_done_lat", done_cyc - rise_cyc, 2);
    chk("t3_busy_end", int'(busy_out), 0);

    // Empty mask for 10 periods, then channel 0
    period_in = 16'd1; burst_len_in = 8'd3; ch_mask_in = 4'b0000;
    start_pulse();
    tick(20);
    chk("t4_no_trig", tq.size(), 0);
    chk("t4_still_busy", int'(busy_out), 1);
    chk("t4_no_done", n_done, 0);
    ch_mask_in = 4'b0001;
    mset = cyc;
    tick(12);
    chk("t4_ntrig", tq.size(), 3);
    if (tq.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t4_ch", cq[i], 0);
      chk("t4_resume_le2", int'(tq[0] - mset <= 2), 1);
    end
    chk("t4_ndone", n_done, 1);

    // en_in dropped mid-burst, then full restart
    period_in = 16'd2; burst_len_in = 8'd6; ch_mask_in = 4'b0110;
    start_pulse();
    for (int i = 0; i < 40 && tq.size() < 2; i++) tick(1);
    chk("t5_two_trig_seen", int'(tq.size() >= 2), 1);
    tick(2);
    en_in = 1'b0;
    #2;
    chk("t5_trig_gated", int'(samp_trig_out), 0);
    tick(4);
    chk("t5_ntrig_abandon", tq.size(), 2);
    chk("t5_no_done", n_done, 0);
    chk("t5_idle", int'(busy_out), 0);
    en_in = 1'b1;
    start_pulse();
    tick(22);
    chk("t5_restart_ntrig", tq.size(), 6);
    if (tq.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t5_ch", cq[i], exp5[i]);
    end
    chk("t5_restart_done", n_done, 1);

    // Reset mid-run, continuous period 7
    mode_in = 1'b0; period_in = 16'd7; ch_mask_in = 4'b1111;
    tick(20);
    chk("t6_running", int'(busy_out), 1);
    rst_in = 1'b0;
    tick(1);
    #2;
    chk("t6_rst_trig", int'(samp_trig_out), 0);
    chk("t6_rst_ch", int'(ch_sel_out), 0);
    chk("t6_rst_busy", int'(busy_out), 0);
    chk("t6_rst_done", int'(done_out), 0);
`ifdef ADC_SAMP_SCHED_CNT_EN
    chk("t6_rst_cnt", int'(trig_cnt_out), 0);
`endif
    en_in = 1'b0;
    rst_in = 1'b1;
    tick(3);
    chk("t6_idle", int'(busy_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
